// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the 2-input gate checker: FSM state encoding,
// reference truth tables for EXPECTED, and the lowest-mismatch helper.
package gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit i is the gate output for row {a,b} = i.
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

  function automatic logic [1:0] first_mismatch(input logic [3:0] diff);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (diff[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gate_checker_if.sv
// Connection between the checker and the gate under test: the checker drives
// the two gate inputs and observes the gate's combinational output.
interface gate_checker_if;
  logic gate_a;
  logic gate_b;
  logic gate_out;

  modport master (output gate_a, output gate_b, input gate_out);
  modport slave  (input gate_a, input gate_b, output gate_out);
endinterface

// File: rtl/gate_checker_settle_timer.sv
// Settle counter: counts enabled cycles and raises last on the final cycle of
// each MAX-cycle window, wrapping to zero on its own.
module settle_timer #(
  parameter int MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  assign last = (cnt_q == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Walks a 2-input gate through rows 00,01,10,11, captures each settled output
// and compares the 4-bit response against EXPECTED.
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECTED      = TT_XOR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  gate_checker_if.master        gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_idx,
  output logic [3:0]            result_vec
);

  state_t     state_q, state_d;
  logic [1:0] row_q;
  logic [1:0] ab_q;
  logic       last;
  logic       capture;
  logic       accept;
  logic       timer_clr;
  logic       timer_en;
  logic [3:0] res_nxt;

  assign timer_en  = (state_q == ST_DRIVE);
  assign timer_clr = !timer_en;
  assign capture   = timer_en && last;
  assign accept    = start && (state_q != ST_DRIVE);

  assign busy        = (state_q == ST_DRIVE);
  assign done        = (state_q == ST_DONE);
  assign gate.gate_a = ab_q[1];
  assign gate.gate_b = ab_q[0];

  settle_timer #(.MAX(SETTLE_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (timer_clr),
    .en    (timer_en),
    .last  (last)
  );

  // Response vector including the row being captured this cycle, so the
  // verdict is ready in the same cycle that done is raised.
  always_comb begin
    res_nxt         = result_vec;
    res_nxt[row_q]  = gate.gate_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: if (capture && row_q == 2'd3) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_DRIVE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q      <= '0;
      ab_q       <= '0;
      result_vec <= '0;
      pass       <= 1'b0;
      fail_idx   <= '0;
    end else if (accept) begin
      row_q      <= '0;
      ab_q       <= '0;
      result_vec <= '0;
      pass       <= 1'b0;
      fail_idx   <= '0;
    end else if (capture) begin
      result_vec <= res_nxt;
      if (row_q == 2'd3) begin
        ab_q     <= '0;
        pass     <= (res_nxt == EXPECTED);
        fail_idx <= first_mismatch(res_nxt ^ EXPECTED);
      end else begin
        row_q <= row_q + 2'd1;
        ab_q  <= row_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: three instances (XOR/stuck GUT S=2, AND GUT S=3,
// XOR GUT S=1) checked cycle by cycle against a truth-table scoreboard.
module tb_gate_checker;
  import gate_checker_pkg::*;

  typedef struct {
    logic [3:0] res;
    logic       pass;
    logic [1:0] fidx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1, start2;
  logic stuck0;

  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [1:0] fidx0, fidx1, fidx2;
  logic [3:0] res0, res1, res2;

  gate_checker_if g0();
  gate_checker_if g1();
  gate_checker_if g2();

  assign g0.gate_out = stuck0 ? 1'b0 : (g0.gate_a ^ g0.gate_b);
  assign g1.gate_out = g1.gate_a & g1.gate_b;
  assign g2.gate_out = g2.gate_a ^ g2.gate_b;

  gate_checker #(.SETTLE_CYCLES(2), .EXPECTED(TT_XOR)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gate(g0), .busy(busy0),
    .done(done0), .pass(pass0), .fail_idx(fidx0), .result_vec(res0));
  gate_checker #(.SETTLE_CYCLES(3), .EXPECTED(TT_XOR)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate(g1), .busy(busy1),
    .done(done1), .pass(pass1), .fail_idx(fidx1), .result_vec(res1));
  gate_checker #(.SETTLE_CYCLES(1), .EXPECTED(TT_XOR)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate(g2), .busy(busy2),
    .done(done2), .pass(pass2), .fail_idx(fidx2), .result_vec(res2));

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;
  exp_t sb[$];

  logic       o_busy, o_done, o_pass;
  logic [1:0] o_ab, o_fidx;
  logic [3:0] o_res;

  always_comb begin
    o_busy = busy0; o_done = done0; o_pass = pass0; o_fidx = fidx0; o_res = res0;
    o_ab   = {g0.gate_a, g0.gate_b};
    case (sel)
      1: begin
        o_busy = busy1; o_done = done1; o_pass = pass1; o_fidx = fidx1; o_res = res1;
        o_ab   = {g1.gate_a, g1.gate_b};
      end
      2: begin
        o_busy = busy2; o_done = done2; o_pass = pass2; o_fidx = fidx2; o_res = res2;
        o_ab   = {g2.gate_a, g2.gate_b};
      end
      default: ;
    endcase
  end

  task automatic set_start(input logic v);
    case (sel)
      1:       start1 = v;
      2:       start2 = v;
      default: start0 = v;
    endcase
  endtask

  // gut: 0 = XOR, 1 = stuck-at-0, 2 = AND
  function automatic exp_t model(input int gut, input logic [3:0] expv);
    exp_t e;
    logic [1:0] r;
    e.res = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      r = 2'(i);
      case (gut)
        1:       e.res[i] = 1'b0;
        2:       e.res[i] = r[1] & r[0];
        default: e.res[i] = r[1] ^ r[0];
      endcase
    end
    e.pass = (e.res == expv);
    e.fidx = 2'd0;
    for (int i = 3; i >= 0; i--) if (e.res[i] != expv[i]) e.fidx = 2'(i);
    return e;
  endfunction

  // One full run on the selected instance; cycle j is sampled 1ns after edge j.
  task automatic drive_run(input int s, input int gut, input bit glitch, input string nm);
    exp_t e;
    sb.push_back(model(gut, TT_XOR));
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1; set_start(1'b0);
    for (int j = 0; j <= 4 * s; j++) begin
      if (j < 4 * s) begin
        n_cmp++; if (o_ab !== 2'(j / s)) begin n_bad++;
          $display("FAIL %s_ab cyc%0d got=%b want=%b", nm, j, o_ab, 2'(j / s)); end
        n_cmp++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_bad++;
          $display("FAIL %s_busy cyc%0d got busy=%b done=%b want 1/0", nm, j, o_busy, o_done); end
        if (j == 0) begin
          n_cmp++; if (o_pass !== 1'b0 || o_res !== 4'b0000) begin n_bad++;
            $display("FAIL %s_clear got pass=%b res=%b want 0/0000", nm, o_pass, o_res); end
        end
        set_start((glitch && j == s + 1) ? 1'b1 : 1'b0);
        @(posedge clk); #1;
      end else begin
        n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ab !== 2'b00) begin n_bad++;
          $display("FAIL %s_done cyc%0d got done=%b busy=%b ab=%b want 1/0/00", nm, j, o_done, o_busy, o_ab); end
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL %s_sb got=empty want=entry", nm);
        end else begin
          e = sb.pop_front();
          n_cmp++; if (o_res !== e.res) begin n_bad++;
            $display("FAIL %s_res got=%b want=%b", nm, o_res, e.res); end
          n_cmp++; if (o_pass !== e.pass) begin n_bad++;
            $display("FAIL %s_pass got=%b want=%b", nm, o_pass, e.pass); end
          n_cmp++; if (o_fidx !== e.fidx) begin n_bad++;
            $display("FAIL %s_fidx got=%0d want=%0d", nm, o_fidx, e.fidx); end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; stuck0 = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy0, done0, pass0, g0.gate_a, g0.gate_b} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctl got=%b want=00000", {busy0, done0, pass0, g0.gate_a, g0.gate_b}); end
    n_cmp++; if (fidx0 !== 2'd0 || res0 !== 4'd0) begin n_bad++;
      $display("FAIL reset_data got fidx=%0d res=%b want 0/0000", fidx0, res0); end
    n_cmp++; if ({busy1, done1, busy2, done2} !== 4'b0) begin n_bad++;
      $display("FAIL reset_others got=%b want=0000", {busy1, done1, busy2, done2}); end
    rst_n = 1'b1;
  endtask

  task automatic test_xor();      sel = 0; drive_run(2, 0, 1'b0, "xor");    endtask
  task automatic test_stuck();    sel = 0; stuck0 = 1'b1; drive_run(2, 1, 1'b0, "stuck"); stuck0 = 1'b0; endtask
  task automatic test_and_s3();   sel = 1; drive_run(3, 2, 1'b0, "and_s3"); endtask
  task automatic test_start_ignored(); sel = 0; drive_run(2, 0, 1'b1, "glitch"); endtask

  task automatic test_midrun_reset();
    sel = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_cmp++; if ({g0.gate_a, g0.gate_b} !== 2'b10) begin n_bad++;
      $display("FAIL mrst_row2 got=%b want=10", {g0.gate_a, g0.gate_b}); end
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    n_cmp++; if ({busy0, done0, pass0, g0.gate_a, g0.gate_b, fidx0, res0} !== 11'b0) begin n_bad++;
      $display("FAIL mrst_outs got=%b want=0", {busy0, done0, pass0, g0.gate_a, g0.gate_b, fidx0, res0}); end
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_bad++;
        $display("FAIL mrst_idle cyc%0d got done=%b busy=%b want 0/0", j, done0, busy0); end
    end
    drive_run(2, 0, 1'b0, "after_rst");
  endtask

  task automatic test_hold();
    exp_t e;
    e = model(0, TT_XOR);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      n_cmp++; if (res0 !== e.res || pass0 !== e.pass || fidx0 !== e.fidx) begin n_bad++;
        $display("FAIL hold_result cyc%0d got res=%b pass=%b fidx=%0d want %b/%b/%0d",
                 j, res0, pass0, fidx0, e.res, e.pass, e.fidx); end
      n_cmp++; if ({g0.gate_a, g0.gate_b, done0, busy0} !== 4'b0) begin n_bad++;
        $display("FAIL hold_idle cyc%0d got=%b want=0000", j, {g0.gate_a, g0.gate_b, done0, busy0}); end
    end
  endtask

  // S=1 with start held: accept, rows 0..3, done, re-accept -> period of 5.
  task automatic test_back_to_back();
    exp_t e;
    int   pos;
    sel = 2;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 15; j++) begin
      pos = j % 5;
      if (pos == 0) sb.push_back(model(0, TT_XOR));
      if (pos < 4) begin
        n_cmp++; if (o_ab !== 2'(pos) || o_busy !== 1'b1 || o_done !== 1'b0) begin n_bad++;
          $display("FAIL b2b_drive cyc%0d got ab=%b busy=%b done=%b want %b/1/0", j, o_ab, o_busy, o_done, 2'(pos)); end
        if (pos == 0) begin
          n_cmp++; if (o_pass !== 1'b0) begin n_bad++;
            $display("FAIL b2b_clear cyc%0d got pass=%b want 0", j, o_pass); end
        end
      end else begin
        n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_ab !== 2'b00) begin n_bad++;
          $display("FAIL b2b_done cyc%0d got done=%b busy=%b ab=%b want 1/0/00", j, o_done, o_busy, o_ab); end
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_sb got=empty want=entry");
        end else begin
          e = sb.pop_front();
          n_cmp++; if (o_res !== e.res || o_pass !== e.pass || o_fidx !== e.fidx) begin n_bad++;
            $display("FAIL b2b_result cyc%0d got %b/%b/%0d want %b/%b/%0d",
                     j, o_res, o_pass, o_fidx, e.res, e.pass, e.fidx); end
        end
        if (j == 14) start2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin n_bad++;
        $display("FAIL b2b_stop cyc%0d got done=%b busy=%b want 0/0", j, done2, busy2); end
      @(posedge clk); #1;
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_xor();
    test_stuck();
    test_and_s3();
    test_start_ignored();
    test_midrun_reset();
    test_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
